alu_seg_display: RTL and testbench

ALU_SEG_DISPLAY -- requirements
Module: alu_seg_display

---
 rtl/alu_disp_pkg.sv | 36 +++
 rtl/alu_seg_display_hex7seg.sv | 11 +
 rtl/alu_seg_display.sv | 135 +++++++++++++
 tb/tb_alu_seg_display.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
// Shared constants and types for the ALU result seven-segment display.
package alu_disp_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low {g,f,e,d,c,b,a}; all segments dark.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex glyph table, entry i holds the pattern for hex digit i.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Frozen copy of the upstream ALU outputs.
    typedef struct packed {
        logic [7:0] res;
        logic       zero;
        logic       cout;
    } hold_t;

endpackage

// File: rtl/alu_seg_display_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
    import alu_disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/alu_seg_display.sv
// Captures or tracks an 8-bit ALU result and scans it across a
// 4-digit multiplexed seven-segment display:
// digit 0/1 = result nibbles, digit 2 = Cout, digit 3 = Zero.
module alu_seg_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_cout,
    input  logic                  capture_btn,
    input  logic                  live,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp,
    output logic                  held_valid
);

    localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] live_sync;
    logic                   btn_prev;
    logic                   btn_s;
    logic                   live_on;
    logic                   capture_pulse;
    logic                   load;
    hold_t                  hold_q;
    logic [CNT_W-1:0]       refresh_cnt;
    logic                   wrap;
    logic [1:0]             digit_idx;
    logic [3:0]             nibble;
    logic [6:0]             hex_seg;
    logic [6:0]             seg_next;
    logic [NUM_DIGITS-1:0]  an_next;
    logic                   dp_next;

    // Two-flop (SYNC_STAGES-deep) synchronizers for the raw button and switch.
    // NOTE: every register here uses non-blocking assignments so all flops
    // sample pre-edge values; blocking ones would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync  <= '0;
            live_sync <= '0;
        end else begin
            btn_sync[0]  <= capture_btn;
            live_sync[0] <= live;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                btn_sync[i]  <= btn_sync[i-1];
                live_sync[i] <= live_sync[i-1];
            end
        end
    end

    assign btn_s         = btn_sync[SYNC_STAGES-1];
    assign live_on       = live_sync[SYNC_STAGES-1];
    assign capture_pulse = btn_s & ~btn_prev;
    assign load          = live_on | capture_pulse;

    // Rising-edge detector: a held button yields a single capture pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_prev <= 1'b0;
        else        btn_prev <= btn_s;
    end

    // Hold registers load on a capture pulse or every cycle in live mode.
    // NOTE: the hold registers are plain flops, so they are cleared by reset
    // to guarantee stale data is discarded; no RAM is involved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            held_valid <= 1'b0;
        end else if (load) begin
            hold_q     <= '{res: alu_result, zero: alu_zero, cout: alu_cout};
            held_valid <= 1'b1;
        end
    end

    assign wrap = (refresh_cnt == CNT_MAX);

    // Refresh divider and digit index; the index advances on each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
            if (wrap) digit_idx <= digit_idx + 1'b1;
        end
    end

    // Digit mux: pick the nibble (or flag) to show on the current digit.
    // NOTE: defaults are assigned first so no path leaves a variable unset,
    // which would otherwise infer a latch.
    always_comb begin
        nibble = 4'h0;
        case (digit_idx)
            2'd0:    nibble = hold_q.res[3:0];
            2'd1:    nibble = hold_q.res[7:4];
            2'd2:    nibble = {3'b000, hold_q.cout};
            default: nibble = {3'b000, hold_q.zero};
        endcase
    end

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (hex_seg)
    );

    // Next display values; dp marks digit 0 only while valid data is frozen.
    always_comb begin
        seg_next = held_valid ? hex_seg : SEG_BLANK;
        an_next  = ~(NUM_DIGITS'(1) << digit_idx);
        dp_next  = ~((digit_idx == 2'd0) & held_valid & ~live_on);
    end

    // Output register: seg, an and dp always change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= 4'b1110;
            dp  <= 1'b1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_alu_seg_display.sv
// Self-checking bench for alu_seg_display with REFRESH_DIV=4.
module tb_alu_seg_display;

    localparam int RD   = 4;
    localparam int S    = 2;
    localparam int MAXN = 4096;

    localparam logic [6:0] TB_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] alu_result = 8'h00;
    logic       alu_zero = 1'b0;
    logic       alu_cout = 1'b0;
    logic       capture_btn = 1'b0;
    logic       live = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       held_valid;

    int checks = 0;
    int passes = 0;

    alu_seg_display #(.REFRESH_DIV(RD), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_cout    (alu_cout),
        .capture_btn (capture_btn),
        .live        (live),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .held_valid  (held_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    // ---------------- behavioural model ----------------
    // Raw inputs are recorded per clock edge since reset release; an input
    // sampled at edge m is seen synchronized S edges later, so a load at
    // edge n comes from live at m=n-S or a 0->1 button step at m=n-S.
    bit        h_btn  [MAXN];
    bit        h_live [MAXN];
    int        mn = 0;
    logic [9:0] m_hold = '0;
    bit        m_hv = 1'b0;
    logic [6:0] exp_seg = 7'b1111111;
    logic [3:0] exp_an  = 4'b1110;
    logic       exp_dp  = 1'b1;
    logic       exp_hv  = 1'b0;

    function automatic bit raw_btn(input int k);
        return (k >= 1 && k < MAXN) ? h_btn[k] : 1'b0;
    endfunction

    function automatic bit raw_live(input int k);
        return (k >= 1 && k < MAXN) ? h_live[k] : 1'b0;
    endfunction

    function automatic logic [6:0] digit_glyph(input int d, input logic [9:0] h);
        case (d)
            0:       return TB_HEX[h[5:2]];
            1:       return TB_HEX[h[9:6]];
            2:       return TB_HEX[{3'b000, h[0]}];
            default: return TB_HEX[{3'b000, h[1]}];
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mn      = 0;
            m_hold  = '0;
            m_hv    = 1'b0;
            exp_seg = 7'b1111111;
            exp_an  = 4'b1110;
            exp_dp  = 1'b1;
            exp_hv  = 1'b0;
        end else begin
            int d;
            mn = mn + 1;
            if (mn < MAXN) begin
                h_btn[mn]  = capture_btn;
                h_live[mn] = live;
            end
            d       = ((mn - 1) / RD) % 4;
            exp_an  = ~(4'b0001 << d);
            exp_seg = m_hv ? digit_glyph(d, m_hold) : 7'b1111111;
            exp_dp  = !(d == 0 && m_hv && !raw_live(mn - S));
            if (raw_live(mn - S) || (raw_btn(mn - S) && !raw_btn(mn - S - 1))) begin
                m_hold = {alu_result, alu_zero, alu_cout};
                m_hv   = 1'b1;
            end
            exp_hv = m_hv;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("seg", 32'(seg), 32'(exp_seg));
        check("an", 32'(an), 32'(exp_an));
        check("dp", 32'(dp), 32'(exp_dp));
        check("held_valid", 32'(held_valid), 32'(exp_hv));
    end

    bit in_live = 1'b0;
    int live_dp_low = 0;
    always @(negedge clk) if (in_live && dp === 1'b0) live_dp_low++;

    // ---------------- stimulus helpers ----------------
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wait_an(input logic [3:0] target);
        int c = 0;
        @(negedge clk);
        while (an !== target && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("wait_an", 32'(an), 32'(target));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step(3);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hE);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_hv", 32'(held_valid), 32'h0);

        // Scan with no capture: digits rotate every 4 cycles, always blank.
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 3)  check("scan_an0", 32'(an), 32'hE);
            if (k == 7)  check("scan_an1", 32'(an), 32'hD);
            if (k == 11) check("scan_an2", 32'(an), 32'hB);
            if (k == 15) check("scan_an3", 32'(an), 32'h7);
            if (k == 15) check("scan_blank", 32'(seg), 32'h7F);
        end

        // Capture 0xA5, zero=0, cout=1.
        step(1);
        alu_result = 8'hA5; alu_zero = 1'b0; alu_cout = 1'b1;
        step(1);
        capture_btn = 1'b1;
        step(3);
        capture_btn = 1'b0;
        step(4 * RD);
        wait_an(4'b1110);
        check("a5_d0", 32'(seg), 32'b0010010);
        check("a5_dp0", 32'(dp), 32'h0);
        wait_an(4'b1101);
        check("a5_d1", 32'(seg), 32'b0001000);
        check("a5_dp1", 32'(dp), 32'h1);
        wait_an(4'b1011);
        check("a5_d2", 32'(seg), 32'b1111001);
        wait_an(4'b0111);
        check("a5_d3", 32'(seg), 32'b1000000);

        // Button held 20 cycles while the ALU changes: first value stays.
        step(1);
        alu_result = 8'h10; alu_zero = 1'b0; alu_cout = 1'b1;
        capture_btn = 1'b1;
        step(5);
        alu_result = 8'h20;
        step(15);
        capture_btn = 1'b0;
        step(20);
        wait_an(4'b1101);
        check("hold_d1", 32'(seg), 32'b1111001);
        wait_an(4'b1110);
        check("hold_d0", 32'(seg), 32'b1000000);

        // Capture landing on the wrap edge into digit 2.
        step(1);
        alu_result = 8'h00; alu_zero = 1'b1; alu_cout = 1'b0;
        begin
            int c = 0;
            while (mn % 16 != 5 && c < 40) begin
                step(1);
                c++;
            end
            check("align", 32'(mn % 16), 32'd5);
        end
        capture_btn = 1'b1;
        repeat (5) @(negedge clk);
        check("coinc_an", 32'(an), 32'hB);
        check("coinc_seg", 32'(seg), 32'b1000000);
        step(1);
        capture_btn = 1'b0;
        wait_an(4'b0111);
        check("coinc_d3", 32'(seg), 32'b1111001);

        // Reset mid-scan on digit 2.
        wait_an(4'b1011);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_an", 32'(an), 32'hE);
        check("mid_rst_dp", 32'(dp), 32'h1);
        check("mid_rst_hv", 32'(held_valid), 32'h0);
        step(2);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_an", 32'(an), 32'hE);
        check("post_rst_seg", 32'(seg), 32'h7F);

        // Live mode with the ALU stepping through every value.
        step(1);
        live = 1'b1;
        in_live = 1'b1;
        for (int i = 0; i < 256; i++) begin
            alu_result = 8'(i);
            alu_zero   = (i == 0);
            alu_cout   = i[0];
            step(1);
        end
        step(8);
        wait_an(4'b1101);
        check("live_d1", 32'(seg), 32'b0001110);
        wait_an(4'b1110);
        check("live_d0", 32'(seg), 32'b0001110);
        in_live = 1'b0;
        check("live_dp_high", 32'(live_dp_low), 32'd0);
        live = 1'b0;
        step(4 * RD * 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
